// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO.
// Width, depth and almost-full threshold live here.
package fifo_pkg;

   localparam int DATA_W_DEF   = 4;
   localparam int ADDR_W_DEF   = 3;
   localparam int AFULL_TH_DEF = 6;

   function automatic int fifo_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port array: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = fifo_depth(ADDR_W);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write port: store the word on a clock edge when enabled.
   always_ff @(posedge clk) begin
      if (we) r_mem[wr_addr] <= wr_data;
   end

   assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with ready/valid on both sides.
// Flags decode from the pointers and the sticky overflow bit.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int AFULL_TH = AFULL_TH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   count,
   output logic              almost_full,
   output logic              overflow
);

   localparam logic [ADDR_W:0] LP_ONE = 1;
   localparam logic [ADDR_W:0] LP_ATH = AFULL_TH[ADDR_W:0];

   logic [ADDR_W:0] r_wr_ptr;
   logic [ADDR_W:0] r_rd_ptr;
   logic            r_ovf;

   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic [ADDR_W:0] w_count;

   // Full when the low bits match but the wrap bits differ.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                    (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

   // A push never leans on a same-cycle pop to make room.
   assign w_push  = wr_valid && !w_full;
   assign w_pop   = rd_ready && !w_empty;
   assign w_count = r_wr_ptr - r_rd_ptr;

   // Pointer and sticky-overflow state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + LP_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_ONE;
         if (wr_valid && w_full) r_ovf <= 1'b1;
      end
   end

   fifo_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we      (w_push),
      .wr_addr (r_wr_ptr[ADDR_W-1:0]),
      .wr_data (wr_data),
      .rd_addr (r_rd_ptr[ADDR_W-1:0]),
      .rd_data (rd_data)
   );

   assign wr_ready    = !w_full;
   assign rd_valid    = !w_empty;
   assign count       = w_count;
   assign almost_full = (w_count >= LP_ATH);
   assign overflow    = r_ovf;

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised synchronous FIFO built on a simple dual-port memory array, with ready/valid handshakes on both sides. It succeeds the single-port 8x4 RAM as the standard buffering element between producer and consumer blocks on one clock domain. It adds configurable width and depth, occupancy tracking, almost-full signalling and overflow detection. Read side is first-word-fall-through: the head entry is presented without a read request.

## Interface
- `DATA_W`, default 4: data word width in bits.
- `ADDR_W`, default 3: address width; DEPTH = 2^ADDR_W entries (8 by default).
- `AFULL_TH`, default 6: `almost_full` asserts when occupancy >= AFULL_TH; legal range 1..DEPTH.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  producer has `wr_data` to push.
- `wr_ready`  out  1  FIFO can accept a push (= not full).
- `wr_data`  in  DATA_W  push data.
- `rd_valid`  out  1  head entry present on `rd_data` (= not empty).
- `rd_ready`  in  1  consumer pops the head this cycle.
- `rd_data`  out  DATA_W  head entry; don't-care while `rd_valid`=0.
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `almost_full`  out  1  `count` >= AFULL_TH.
- `overflow`  out  1  sticky: set when a push was attempted while full.

## Operation
- Push occurs when `wr_valid` && `wr_ready` on a clock edge. The data is written at `mem[wr_ptr]` and `wr_ptr` increments.
- Pop occurs when `rd_valid` && `rd_ready`. `rd_ptr` increments and the memory is not modified.
- Pointers are ADDR_W+1 bits wide and wrap naturally modulo 2·DEPTH. The low ADDR_W bits index the memory.
  - Empty: pointers are equal.
  - Full: low bits are equal and MSBs differ.
- `count` update per cycle:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Simultaneous push and pop:
  - When neither full nor empty, both are performed.
  - When full, `wr_ready`=0, so only the pop happens. A write is never accepted on the strength of a same-cycle pop.
  - When empty, `rd_valid`=0, so only the push happens. There is no bypass: written data appears on the next cycle.
- `overflow` sets on any edge where `wr_valid`=1 and full=1. It is cleared only by reset.
- Pop while empty (`rd_ready`=1 with `rd_valid`=0) is ignored. It is not an error and has no flag.
- `wr_data` is ignored unless a push occurs.

## Timing
- Reset values (async assert, sync release):
  - `wr_ptr` = 0, `rd_ptr` = 0, `count` = 0.
  - `rd_valid` = 0, `wr_ready` = 1, `almost_full` = 0, `overflow` = 0.
  - Memory contents are not reset.
- Write-to-read latency is 1 cycle. A push at edge N makes `rd_valid`=1 and `rd_data` valid after edge N, when the FIFO was empty.
- `rd_data` is a combinational read of `mem[rd_ptr]`. It updates in the same cycle `rd_ptr` advances.
- `wr_ready`, `rd_valid`, `almost_full` and `overflow` are decoded from registered state only. None of them depends combinationally on `wr_valid` or `rd_ready`.
- Throughput is one push and one pop per cycle sustained.
- Reset asserted mid-operation discards all contents immediately. The FIFO reads as empty from assertion onward.

## Structure
- Shared package `fifo_pkg` holds:
  - default parameter constants (`DATA_W`, `ADDR_W`, `AFULL_TH`);
  - the depth function DEPTH = 1 << ADDR_W.
- Sub-module `fifo_ram`: parametrised simple dual-port array.
  - Synchronous write with `we`, `wr_addr`, `wr_data`.
  - Asynchronous read with `rd_addr`, `rd_data`.
  - It is the generalised form of the existing 8x4 RAM.
- `sync_fifo` owns the pointers, count, flags and handshake logic.

## Test plan
All scenarios use DATA_W=4, ADDR_W=3, AFULL_TH=6.
- Reset, no traffic -> `count`=0, `rd_valid`=0, `wr_ready`=1, `almost_full`=0, `overflow`=0.
- Push 0x1..0x8 on consecutive cycles with `rd_ready`=0 -> `almost_full` rises after the 6th push, `wr_ready`=0 after the 8th, `count`=8.
- Then pop 8 times -> `rd_data` sequence is 0x1..0x8, ending with `rd_valid`=0.
- Fill to 8, then hold `wr_valid`=1 with 0xF for one cycle -> `overflow`=1 and sticks; `count` stays 8; 0xF is never read out.
- With `count`=3, push and pop in the same cycle for 20 cycles -> `count` stays 3, data is in order, and both pointers wrap past 7 without loss.
- Push a single 0xA into an empty FIFO -> `rd_valid`=1 and `rd_data`=0xA on the next cycle.
- Push 0xA, 0xB, assert `rst_n`=0 mid-cycle -> `count`=0 and `rd_valid`=0 immediately.
- Release reset, push 0xC -> the first pop returns 0xC.
